// File: rtl/sbox_lane_arbiter.sv
// Time-shares one LANE_BYTES-wide sub_bytes lane between serialised block requests and key words.
// Define SBOX_ARB_KEY_PREEMPT_EN to let one key word slip in between beats of a running block.
module sbox_lane_arbiter #(
    parameter int unsigned BLOCK_BYTES = 16,
    parameter int unsigned LANE_BYTES  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     blk_v_i,
    input  logic [BLOCK_BYTES*8-1:0] blk_i,
    output logic                     blk_ready_o,
    output logic                     blk_res_v_o,
    output logic [BLOCK_BYTES*8-1:0] blk_res_o,
    input  logic                     blk_res_ready_i,
    input  logic                     key_v_i,
    input  logic [LANE_BYTES*8-1:0]  key_i,
    output logic                     key_ready_o,
    output logic                     key_res_v_o,
    output logic [LANE_BYTES*8-1:0]  key_res_o,
    input  logic                     key_res_ready_i,
    output logic [LANE_BYTES*8-1:0]  lane_o,
    input  logic [LANE_BYTES*8-1:0]  lane_i,
    output logic                     busy_o
);

    localparam int unsigned BW   = BLOCK_BYTES * 8;
    localparam int unsigned LW   = LANE_BYTES * 8;
    localparam int unsigned NB   = BLOCK_BYTES / LANE_BYTES;
    localparam int unsigned CntW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(NB - 1);

    typedef enum logic [1:0] {StIdle, StBlkRun, StBlkDone, StKeyRun} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            prio_key_q, prio_key_d;
    logic [BW-1:0]   blk_reg_q, blk_reg_d, blk_res_q, blk_res_d;
    logic [LW-1:0]   key_reg_q, key_reg_d, key_res_q, key_res_d;
    logic            blk_res_v_q, blk_res_v_d, key_res_v_q, key_res_v_d;
    logic            blk_base, key_base, blk_grant, key_grant, last_beat;
    logic [31:0]     sh;
    logic [BW-1:0]   slot_mask, slot_data;
`ifdef SBOX_ARB_KEY_PREEMPT_EN
    logic            preempted_q, preempted_d, resume_q, resume_d;
`endif

    assign last_beat = (cnt_q == LastBeat);
    // Beat k lives at bit offset LW*(NB-1-k): MSB slice first.
    assign sh        = LW * (NB - 1 - 32'(cnt_q));
    assign slot_mask = BW'({LW{1'b1}}) << sh;
    assign slot_data = BW'(lane_i) << sh;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            prio_key_q  <= 1'b1;
            blk_reg_q   <= '0;
            blk_res_q   <= '0;
            key_reg_q   <= '0;
            key_res_q   <= '0;
            blk_res_v_q <= 1'b0;
            key_res_v_q <= 1'b0;
`ifdef SBOX_ARB_KEY_PREEMPT_EN
            preempted_q <= 1'b0;
            resume_q    <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            prio_key_q  <= prio_key_d;
            blk_reg_q   <= blk_reg_d;
            blk_res_q   <= blk_res_d;
            key_reg_q   <= key_reg_d;
            key_res_q   <= key_res_d;
            blk_res_v_q <= blk_res_v_d;
            key_res_v_q <= key_res_v_d;
`ifdef SBOX_ARB_KEY_PREEMPT_EN
            preempted_q <= preempted_d;
            resume_q    <= resume_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_key_d  = prio_key_q;
        blk_reg_d   = blk_reg_q;
        blk_res_d   = blk_res_q;
        key_reg_d   = key_reg_q;
        key_res_d   = key_res_q;
        blk_res_v_d = blk_res_v_q;
        key_res_v_d = key_res_v_q;
`ifdef SBOX_ARB_KEY_PREEMPT_EN
        preempted_d = preempted_q;
        resume_d    = resume_q;
`endif
        blk_grant = blk_v_i && blk_ready_o;
        key_grant = key_v_i && key_ready_o;
        if (blk_res_v_q && blk_res_ready_i) blk_res_v_d = 1'b0;
        if (key_res_v_q && key_res_ready_i) key_res_v_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (key_grant) begin
                    state_d    = StKeyRun;
                    key_reg_d  = key_i;
                    prio_key_d = 1'b0;
                end else if (blk_grant) begin
                    state_d    = StBlkRun;
                    blk_reg_d  = blk_i;
                    cnt_d      = '0;
                    prio_key_d = 1'b1;
`ifdef SBOX_ARB_KEY_PREEMPT_EN
                    preempted_d = 1'b0;
`endif
                end
            end
            StBlkRun: begin
                blk_res_d = (blk_res_q & ~slot_mask) | slot_data;
                if (last_beat) begin
                    state_d     = StBlkDone;
                    blk_res_v_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`ifdef SBOX_ARB_KEY_PREEMPT_EN
                    if (key_grant) begin
                        state_d     = StKeyRun;
                        key_reg_d   = key_i;
                        preempted_d = 1'b1;
                        resume_d    = 1'b1;
                    end
`endif
                end
            end
            StBlkDone: state_d = StIdle;
            StKeyRun: begin
                key_res_d   = lane_i;
                key_res_v_d = 1'b1;
                state_d     = StIdle;
`ifdef SBOX_ARB_KEY_PREEMPT_EN
                if (resume_q) state_d = StBlkRun;
                resume_d = 1'b0;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        blk_base = (state_q == StIdle) && !blk_res_v_q;
        key_base = (state_q == StIdle) && !key_res_v_q;
`ifdef SBOX_ARB_KEY_PREEMPT_EN
        key_base = key_base || ((state_q == StBlkRun) && !key_res_v_q && !last_beat &&
                                !preempted_q);
`endif
        // Under contention only the prioritised side sees ready, so v && ready is a real grant.
        blk_ready_o = blk_base && !(key_v_i && key_base && prio_key_q);
        key_ready_o = key_base && !(blk_v_i && blk_base && !prio_key_q);
        busy_o      = (state_q != StIdle);
        case (state_q)
            StBlkRun: lane_o = LW'(blk_reg_q >> sh);
            StKeyRun: lane_o = key_reg_q;
            default:  lane_o = '0;
        endcase
    end

    assign blk_res_v_o = blk_res_v_q;
    assign blk_res_o   = blk_res_q;
    assign key_res_v_o = key_res_v_q;
    assign key_res_o   = key_res_q;

endmodule

// File: tb/tb_sbox_lane_arbiter.sv
// Scoreboard bench for sbox_lane_arbiter; the lane is closed through a behavioural AES S-box.
// Covers SBOX_ARB_KEY_PREEMPT_EN timing when the macro is defined for both files.
module tb_sbox_lane_arbiter;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] A_IN   = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] A_OUT  = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [127:0] F_IN   = {16{8'hff}};
    localparam logic [127:0] F_OUT  = {16{8'h16}};
    localparam logic [127:0] Z_OUT  = {16{8'h63}};
    localparam logic [31:0]  K1_IN  = 32'h09cf4f3c;
    localparam logic [31:0]  K1_OUT = 32'h018a84eb;
    localparam logic [31:0]  K2_IN  = 32'h01234567;
    localparam logic [31:0]  K2_OUT = 32'h7c266e85;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_v_i, blk_ready_o, blk_res_v_o, blk_res_ready_i;
    logic [127:0] blk_i, blk_res_o;
    logic         key_v_i, key_ready_o, key_res_v_o, key_res_ready_i, busy_o;
    logic [31:0]  key_i, key_res_o, lane_o, lane_i;

    int           total = 0;
    int           bad = 0;
    logic [127:0] blk_exp_q[$];
    logic [31:0]  key_exp_q[$];
    int           glog[$];
    logic         log_en = 1'b0;

    always #5 clk = ~clk;

    sbox_lane_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .blk_v_i         (blk_v_i),
        .blk_i           (blk_i),
        .blk_ready_o     (blk_ready_o),
        .blk_res_v_o     (blk_res_v_o),
        .blk_res_o       (blk_res_o),
        .blk_res_ready_i (blk_res_ready_i),
        .key_v_i         (key_v_i),
        .key_i           (key_i),
        .key_ready_o     (key_ready_o),
        .key_res_v_o     (key_res_v_o),
        .key_res_o       (key_res_o),
        .key_res_ready_i (key_res_ready_i),
        .lane_o          (lane_o),
        .lane_i          (lane_i),
        .busy_o          (busy_o)
    );

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    always_comb begin
        lane_i = '0;
        for (int i = 0; i < 4; i++) lane_i[8*i +: 8] = sb(lane_o[8*i +: 8]);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (blk_exp_q.size() != 0 || key_exp_q.size() != 0); i++) tick();
        chk("drain_blk", blk_exp_q.size(), 0);
        chk("drain_key", key_exp_q.size(), 0);
    endtask

    // Monitor: a result is consumed at the next edge whenever valid && ready at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (blk_res_v_o && blk_res_ready_i) begin
                if (blk_exp_q.size() == 0) chk("blk_unexpected", blk_res_o, 'x);
                else chk("blk_res", blk_res_o, blk_exp_q.pop_front());
            end
            if (key_res_v_o && key_res_ready_i) begin
                if (key_exp_q.size() == 0) chk("key_unexpected", key_res_o, 'x);
                else chk("key_res", key_res_o, key_exp_q.pop_front());
            end
            if (log_en && key_v_i && key_ready_o) glog.push_back(1);
            if (log_en && blk_v_i && blk_ready_o) glog.push_back(2);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   blk_first, key_first;
        logic kacc, seen;
        rst_n = 1'b0;
        blk_v_i = 1'b0; blk_i = '0; blk_res_ready_i = 1'b1;
        key_v_i = 1'b0; key_i = '0; key_res_ready_i = 1'b1;
        tick(); tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_blk_v", blk_res_v_o, 0);
        chk("rst_key_v", key_res_v_o, 0);
        chk("rst_lane", lane_o, 0);
        chk("rst_blk_res", blk_res_o, 0);
        chk("rst_key_res", key_res_o, 0);
        chk("rst_blk_ready", blk_ready_o, 1);
        rst_n = 1'b1;
        tick();

        // Single block: lane sequence and latency
        blk_v_i = 1'b1; blk_i = A_IN; blk_exp_q.push_back(A_OUT);
        tick();
        blk_v_i = 1'b0; blk_i = '0;
        chk("t1_lane0", lane_o, 32'h00102030);
        chk("t1_busy", busy_o, 1);
        tick(); chk("t1_lane1", lane_o, 32'h40506070);
        tick(); chk("t1_lane2", lane_o, 32'h8090a0b0);
        tick(); chk("t1_lane3", lane_o, 32'hc0d0e0f0);
        chk("t1_not_yet", blk_res_v_o, 0);
        tick(); chk("t1_latency", blk_res_v_o, 1);
        chk("t1_done_lane", lane_o, 0);
        drain();

        // Single key word
        key_v_i = 1'b1; key_i = K1_IN; key_exp_q.push_back(K1_OUT);
        tick();
        key_v_i = 1'b0; key_i = '0;
        chk("t2_lane", lane_o, K1_IN);
        tick(); chk("t2_latency", key_res_v_o, 1);
        drain();

        // Both valid from reset: key, block, key
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        blk_v_i = 1'b1; blk_i = A_IN; key_v_i = 1'b1; key_i = K1_IN;
        key_exp_q.push_back(K1_OUT); blk_exp_q.push_back(A_OUT); key_exp_q.push_back(K1_OUT);
        log_en = 1'b1;
        for (int i = 0; i < 40 && glog.size() < 3; i++) tick();
        blk_v_i = 1'b0; key_v_i = 1'b0; log_en = 1'b0;
        while (glog.size() < 3) glog.push_back(0);
        chk("t3_grant0_key", glog[0], 1);
        chk("t3_grant1_blk", glog[1], 2);
        chk("t3_grant2_key", glog[2], 1);
        drain();

        // Backpressure on the block result while a key is served
        blk_res_ready_i = 1'b0;
        blk_v_i = 1'b1; blk_i = F_IN; blk_exp_q.push_back(F_OUT);
        tick();
        blk_v_i = 1'b0;
        repeat (4) tick();
        chk("t4_valid", blk_res_v_o, 1);
        blk_v_i = 1'b1; blk_i = '0;
        key_v_i = 1'b1; key_i = K2_IN; key_exp_q.push_back(K2_OUT);
        for (int i = 0; i < 4; i++) begin
            kacc = key_v_i && key_ready_o;
            tick();
            if (kacc) key_v_i = 1'b0;
            chk("t4_hold_v", blk_res_v_o, 1);
            chk("t4_hold_res", blk_res_o, F_OUT);
            chk("t4_blk_ready", blk_ready_o, 0);
        end
        chk("t4_key_served", key_exp_q.size(), 0);
        blk_exp_q.push_back(Z_OUT);
        blk_res_ready_i = 1'b1;
        tick(); chk("t4_ready_after", blk_ready_o, 1);
        tick(); chk("t4_next_accept", busy_o, 1);
        blk_v_i = 1'b0;
        drain();

        // Reset during beat 2
        blk_v_i = 1'b1; blk_i = A_IN;
        tick();
        blk_v_i = 1'b0;
        tick(); tick();
        chk("t5_beat2", lane_o, 32'h8090a0b0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t5_busy", busy_o, 0);
        chk("t5_blk_v", blk_res_v_o, 0);
        chk("t5_key_v", key_res_v_o, 0);
        chk("t5_lane", lane_o, 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (blk_res_v_o) seen = 1'b1;
        end
        chk("t5_no_partial", seen, 0);
        blk_v_i = 1'b1; blk_i = A_IN; blk_exp_q.push_back(A_OUT);
        tick();
        blk_v_i = 1'b0;
        drain();

        // Key arriving during beat 1
        blk_v_i = 1'b1; blk_i = A_IN; blk_exp_q.push_back(A_OUT); key_exp_q.push_back(K2_OUT);
        tick();
        blk_v_i = 1'b0;
        blk_first = 0; key_first = 0;
        for (int c = 1; c <= 10; c++) begin
            kacc = key_v_i && key_ready_o;
            tick();
            if (kacc) key_v_i = 1'b0;
            if (blk_res_v_o && blk_first == 0) blk_first = c;
            if (key_res_v_o && key_first == 0) key_first = c;
            if (c == 1) begin
                key_v_i = 1'b1; key_i = K2_IN;
            end
        end
`ifdef SBOX_ARB_KEY_PREEMPT_EN
        chk("t6_blk_latency", blk_first, 5);
        chk("t6_key_latency", key_first, 3);
`else
        chk("t6_blk_latency", blk_first, 4);
        chk("t6_key_latency", key_first, 7);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sbox_lane_arbiter.md
Name: sbox_lane_arbiter

Overview:
- Shares one narrow S-box lane, an external sub_bytes instance with size = LANE_BYTES, between two requesters.
- Requester 1 is the round datapath, which sends full 16-byte blocks serialised over several beats.
- Requester 2 is key expansion, which sends single 32-bit words (SubWord).
- Sits between the round controller / key schedule and the shared combinational sub_bytes lane; replaces a full 16-S-box bank to save area.

Parameters:
- BLOCK_BYTES, 16, bytes per block request; must be a multiple of LANE_BYTES.
- LANE_BYTES, 4, bytes substituted per cycle; equals the sub_bytes instance size and the key word width in bytes.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- blk_v_i  input  1  block request valid
- blk_i  input  BLOCK_BYTES*8  block to substitute; byte 0 in the MSBs
- blk_ready_o  output  1  block request accepted when blk_v_i && blk_ready_o
- blk_res_v_o  output  1  block result valid
- blk_res_o  output  BLOCK_BYTES*8  substituted block
- blk_res_ready_i  input  1  consumer takes the block result
- key_v_i  input  1  key word request valid
- key_i  input  LANE_BYTES*8  word to substitute
- key_ready_o  output  1  key request accepted when key_v_i && key_ready_o
- key_res_v_o  output  1  key result valid
- key_res_o  output  LANE_BYTES*8  substituted word
- key_res_ready_i  input  1  consumer takes the key result
- lane_o  output  LANE_BYTES*8  bytes driven into the sub_bytes lane
- lane_i  input  LANE_BYTES*8  combinational sub_bytes output for lane_o
- busy_o  output  1  state != IDLE

Behaviour:
- **Reset** (rst_n low at a clock edge):
  - State = IDLE; beat counter = 0; priority = KEY.
  - All *_v_o, busy_o and lane_o = 0; blk_res_o and key_res_o = 0.
- **Reset mid-operation:** aborts the operation and drops all pending results. No partial result is ever presented.
- **States:** IDLE, BLK_RUN, BLK_DONE, KEY_RUN.
- **Beats:** NB = BLOCK_BYTES/LANE_BYTES.
  - Beat k drives lane_o = blk_i_reg[BLOCK_BYTES*8-1-k*LANE_BYTES*8 -: LANE_BYTES*8], i.e. MSB slice first.
  - lane_i is written into the same slice of blk_res_o at the end of that cycle.
- **Request registers:** blk_i and key_i are captured into internal registers on acceptance. Requesters may change their inputs afterwards.
- **Ready signals:**
  - blk_ready_o = (state == IDLE) && !blk_res_v_o.
  - key_ready_o = (state == IDLE) && !key_res_v_o.
- **IDLE arbitration** (only among requests whose ready is high):
  - Only one requester valid: grant it.
  - Both valid: grant the side named by priority, then flip priority to the other side.
  - A single uncontested grant also sets priority to the other side.
- **IDLE → BLK_RUN** on block accept; counter = 0.
- **BLK_RUN:** one beat per cycle. At beat NB-1, go to BLK_DONE and set blk_res_v_o = 1.
  - Latency: accept at edge T → blk_res_v_o high from edge T+NB (4 cycles by default).
- **BLK_DONE:** one cycle, then go to IDLE. blk_res_v_o stays high until blk_res_ready_i is sampled high, then clears.
  - While blk_res_v_o is set, no new block is accepted. Key requests are still served.
- **IDLE → KEY_RUN** on key accept.
  - KEY_RUN drives lane_o = key_reg, captures lane_i into key_res_o, sets key_res_v_o, and returns to IDLE.
  - Latency: 1 cycle.
- **Result holding:** key_res_v_o holds until key_res_ready_i. Results stay stable while valid.
- **Idle lane:** lane_o = 0 in IDLE and BLK_DONE.
- **Simultaneous ready and new request:** results and requests are independent. A result may be consumed on the same edge a new request of the other type is accepted.
- **Edge cases:**
  - blk_res_ready_i high with no result pending: ignored.
  - key_v_i dropped before being accepted: no effect.

Optional Feature:
- **Macro:** SBOX_ARB_KEY_PREEMPT_EN.
- **Defined:**
  - During BLK_RUN, key_ready_o is also high when !key_res_v_o and the beat just completed is < NB-1.
  - An accepted key inserts one KEY_RUN cycle after the current beat. The counter is held, and the arbiter then resumes BLK_RUN at the next beat.
  - Block latency grows by 1 per preemption. At most one preemption per block.
- **Undefined:** keys wait until IDLE. No preemption logic is synthesised.

Test Plan:
1. **Single block:** blk_i = 00102030405060708090a0b0c0d0e0f0, blk_res_ready_i = 1 → blk_res_o = 63cab7040953d051cd60e0e7ba70e18c; blk_res_v_o high exactly NB = 4 cycles after accept; lane_o sequence 00102030, 40506070, 8090a0b0, c0d0e0f0.
2. **Single key word:** key_i = 09cf4f3c → key_res_o = 018a84eb one cycle after accept.
3. **Both valid in IDLE from reset:** key granted first (018a84eb), then the block; with both held valid, grants alternate key/block/key.
4. **Backpressure:** hold blk_res_ready_i = 0 → blk_res_v_o and blk_res_o stay stable, blk_ready_o = 0; a key request is still served; release ready → next block accepted the following IDLE cycle.
5. **Reset mid-operation:** rst_n low during beat 2 → next cycle all valids 0, busy_o = 0, state = IDLE; a fresh block then completes correctly.
6. **Preemption (SBOX_ARB_KEY_PREEMPT_EN):** key arrives during beat 1 → key result 1 cycle later; block result correct and valid at NB+1 cycles; without the macro the key result appears only after the block finishes.
